// File: rtl/stb_drain_controller.sv
// Store-buffer drain controller: pops the head store and issues it to the dcache one at a time.
// Optional ack watchdog enabled by defining STB_DRAIN_TIMEOUT_EN.
module stb_drain_controller #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stb_empty,
  input  logic [ADDR_W-1:0]     stb_head_addr,
  input  logic [DATA_W-1:0]     stb_head_data,
  input  logic [DATA_W/8-1:0]   stb_head_sel,
  output logic                  stb_rd_en,
  input  logic                  lsummu2dcache_ld_req,
  input  logic                  lsummu2stb_fence,
  output logic                  stb2lsummu_fence_done,
  output logic                  stb2dcache_req,
  output logic                  stb2dcache_w_en,
  output logic [ADDR_W-1:0]     stb2dcache_addr,
  output logic [DATA_W-1:0]     stb2dcache_wdata,
  output logic [DATA_W/8-1:0]   stb2dcache_sel,
  input  logic                  dcache2stb_ack,
  output logic                  stb2lsummu_drain_err
);

  localparam int unsigned SelW = DATA_W / 8;

  typedef enum logic [1:0] {
    DrIdle = 2'b00,
    DrReq  = 2'b01
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [SelW-1:0]   sel_q, sel_d;
  logic              fence_pending_q, fence_pending_d;
  logic              req_active;

`ifdef STB_DRAIN_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] wd_cnt_q, wd_cnt_d;
  logic            retry_q, retry_d;
  logic            err_q, err_d;

  // retry_q holds req low for the single re-issue bubble after a timeout
  assign req_active = (state_q == DrReq) && !retry_q;
  assign stb2lsummu_drain_err = err_q;

  always_comb begin
    wd_cnt_d = '0;
    retry_d  = 1'b0;
    err_d    = err_q;
    if (req_active && !dcache2stb_ack) begin
      if (wd_cnt_q == CntMax) begin
        retry_d = 1'b1;
        err_d   = 1'b1;
      end else begin
        wd_cnt_d = wd_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt_q <= '0;
      retry_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      retry_q  <= retry_d;
      err_q    <= err_d;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg   = ^TIMEOUT_CYCLES;
  assign req_active           = (state_q == DrReq);
  assign stb2lsummu_drain_err = 1'b0;
`endif

  always_comb begin
    state_d               = state_q;
    addr_d                = addr_q;
    data_d                = data_q;
    sel_d                 = sel_q;
    fence_pending_d       = fence_pending_q;
    stb_rd_en             = 1'b0;
    // rst_n gating keeps the combinational pulses quiet while reset is held
    stb2lsummu_fence_done = rst_n && fence_pending_q && stb_empty && (state_q == DrIdle);

    case (state_q)
      DrIdle: begin
        if (rst_n && !stb_empty && (!lsummu2dcache_ld_req || fence_pending_q)) begin
          stb_rd_en = 1'b1;
          addr_d    = stb_head_addr;
          data_d    = stb_head_data;
          sel_d     = stb_head_sel;
          state_d   = DrReq;
        end
      end
      DrReq: begin
        if (req_active && dcache2stb_ack) begin
          state_d = DrIdle;
        end
      end
      default: state_d = DrIdle;
    endcase

    if (stb2lsummu_fence_done) begin
      fence_pending_d = 1'b0;
    end else if (lsummu2stb_fence && !fence_pending_q) begin
      fence_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= DrIdle;
      addr_q          <= '0;
      data_q          <= '0;
      sel_q           <= '0;
      fence_pending_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      data_q          <= data_d;
      sel_q           <= sel_d;
      fence_pending_q <= fence_pending_d;
    end
  end

  assign stb2dcache_req   = req_active;
  assign stb2dcache_w_en  = req_active;
  assign stb2dcache_addr  = addr_q;
  assign stb2dcache_wdata = data_q;
  assign stb2dcache_sel   = sel_q;

endmodule

// File: tb/tb_stb_drain_controller.sv
// Directed self-checking bench for stb_drain_controller with a queue-backed store buffer
// and a fixed-latency dcache responder.
module tb_stb_drain_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stb_empty;
  logic [31:0] stb_head_addr;
  logic [31:0] stb_head_data;
  logic [3:0]  stb_head_sel;
  logic        stb_rd_en;
  logic        ld_req;
  logic        fence;
  logic        fence_done;
  logic        req;
  logic        w_en;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic [3:0]  wsel;
  logic        ack;
  logic        drain_err;

  logic        resp_ack = 1'b0;
  logic        spur_ack = 1'b0;
  int          ack_lat  = 1;
  int          req_cnt  = 0;
  logic        pop_n;

  typedef logic [67:0] ent_t;
  ent_t q[$];
  ent_t popped;

  int n_vec  = 0;
  int n_miss = 0;

  assign ack = resp_ack | spur_ack;

  always #5 clk = ~clk;

  stb_drain_controller #(
    .ADDR_W        (32),
    .DATA_W        (32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .stb_empty            (stb_empty),
    .stb_head_addr        (stb_head_addr),
    .stb_head_data        (stb_head_data),
    .stb_head_sel         (stb_head_sel),
    .stb_rd_en            (stb_rd_en),
    .lsummu2dcache_ld_req (ld_req),
    .lsummu2stb_fence     (fence),
    .stb2lsummu_fence_done(fence_done),
    .stb2dcache_req       (req),
    .stb2dcache_w_en      (w_en),
    .stb2dcache_addr      (waddr),
    .stb2dcache_wdata     (wdata),
    .stb2dcache_sel       (wsel),
    .dcache2stb_ack       (ack),
    .stb2lsummu_drain_err (drain_err)
  );

  function automatic void refresh();
    if (q.size() == 0) begin
      stb_empty = 1'b1;
      {stb_head_addr, stb_head_data, stb_head_sel} = '0;
    end else begin
      stb_empty = 1'b0;
      {stb_head_addr, stb_head_data, stb_head_sel} = q[0];
    end
  endfunction

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    q.push_back({a, d, s});
    refresh();
  endtask

  // Store buffer: pop on an rd_en seen mid-cycle, update head just after the edge
  initial forever begin
    @(negedge clk);
    pop_n = stb_rd_en;
    @(posedge clk);
    #1;
    if (pop_n && q.size() != 0) popped = q.pop_front();
    refresh();
  end

  // Dcache: ack in the ack_lat-th cycle of req; ack_lat 0 means never
  initial forever begin
    @(negedge clk);
    if (req && ack_lat != 0) begin
      req_cnt++;
      if (req_cnt == ack_lat) begin
        resp_ack = 1'b1;
        req_cnt  = 0;
      end
    end else begin
      req_cnt = 0;
    end
    @(posedge clk);
    #1;
    resp_ack = 1'b0;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
    $fatal(1, "bench timeout");
  end

  task automatic test_reset();
    ld_req = 0; fence = 0; ack_lat = 1;
    q.delete(); refresh();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({req, w_en, stb_rd_en, fence_done, drain_err} !== 5'b0) begin
      n_miss++;
      $display("FAIL reset_ctrl: got %b want 00000",
               {req, w_en, stb_rd_en, fence_done, drain_err});
    end
    n_vec++;
    if ({waddr, wdata, wsel} !== 68'h0) begin
      n_miss++;
      $display("FAIL reset_payload: got %h want 0", {waddr, wdata, wsel});
    end
    push(32'h0000_0ABC, 32'h1234_5678, 4'h1);
    #1;
    n_vec++;
    if (stb_rd_en !== 1'b0) begin
      n_miss++;
      $display("FAIL reset_rd_en_held: got %b want 0", stb_rd_en);
    end
    q.delete(); refresh();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_store();
    logic exp_rd, exp_req;
    ack_lat = 3;
    @(posedge clk); #1;
    push(32'h0000_1000, 32'hDEAD_BEEF, 4'hF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      exp_rd  = (i == 0);
      exp_req = (i >= 1 && i <= 3);
      n_vec++;
      if ({stb_rd_en, req, w_en} !== {exp_rd, exp_req, exp_req}) begin
        n_miss++;
        $display("FAIL single_ctrl[%0d]: got rd/req/wen %b want %b", i,
                 {stb_rd_en, req, w_en}, {exp_rd, exp_req, exp_req});
      end
      if (exp_req) begin
        n_vec++;
        if ({waddr, wdata, wsel} !== {32'h0000_1000, 32'hDEAD_BEEF, 4'hF}) begin
          n_miss++;
          $display("FAIL single_payload[%0d]: got %h want 00001000deadbeeff", i,
                   {waddr, wdata, wsel});
        end
      end
    end
  endtask

  task automatic test_load_priority();
    logic [4:0] rd_pat  = 5'b00101;
    logic [4:0] req_pat = 5'b01010;
    ack_lat = 1;
    @(posedge clk); #1;
    ld_req = 1'b1;
    push(32'h0000_2000, 32'h1111_1111, 4'h3);
    push(32'h0000_2004, 32'h2222_2222, 4'hC);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_vec++;
      if ({stb_rd_en, req} !== 2'b00) begin
        n_miss++;
        $display("FAIL ldprio_block[%0d]: got rd/req %b want 00", i, {stb_rd_en, req});
      end
    end
    @(posedge clk); #1;
    ld_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_vec++;
      if ({stb_rd_en, req} !== {rd_pat[i], req_pat[i]}) begin
        n_miss++;
        $display("FAIL ldprio_drain[%0d]: got rd/req %b want %b", i, {stb_rd_en, req},
                 {rd_pat[i], req_pat[i]});
      end
      if (req_pat[i]) begin
        n_vec++;
        if (waddr !== ((i == 1) ? 32'h0000_2000 : 32'h0000_2004)) begin
          n_miss++;
          $display("FAIL ldprio_addr[%0d]: got %h", i, waddr);
        end
      end
    end
  endtask

  task automatic test_fence();
    logic [8:0] rd_pat   = 9'b000101010;
    logic [8:0] req_pat  = 9'b001010100;
    logic [8:0] done_pat = 9'b010000000;
    int         n_done   = 0;
    ack_lat = 1;
    @(posedge clk); #1;
    ld_req = 1'b1;
    fence  = 1'b1;
    push(32'h0000_3000, 32'hA000_0000, 4'h1);
    push(32'h0000_3004, 32'hA000_0001, 4'h2);
    push(32'h0000_3008, 32'hA000_0002, 4'h4);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (fence_done) n_done++;
      n_vec++;
      if ({stb_rd_en, req, fence_done} !== {rd_pat[i], req_pat[i], done_pat[i]}) begin
        n_miss++;
        $display("FAIL fence_ctrl[%0d]: got rd/req/done %b want %b", i,
                 {stb_rd_en, req, fence_done}, {rd_pat[i], req_pat[i], done_pat[i]});
      end
      if (req_pat[i]) begin
        n_vec++;
        if (waddr !== 32'h0000_3000 + 32'((i - 2) * 2)) begin
          n_miss++;
          $display("FAIL fence_addr[%0d]: got %h want %h", i, waddr,
                   32'h0000_3000 + 32'((i - 2) * 2));
        end
      end
      if (i == 7) begin
        @(posedge clk); #1;
        fence = 1'b0;
      end
    end
    n_vec++;
    if (n_done != 1) begin
      n_miss++;
      $display("FAIL fence_done_count: got %0d want 1", n_done);
    end
    ld_req = 1'b0;
  endtask

  task automatic test_fence_empty();
    logic [2:0] done_pat = 3'b010;
    @(posedge clk); #1;
    fence = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if ({stb_rd_en, req, fence_done} !== {2'b00, done_pat[i]}) begin
        n_miss++;
        $display("FAIL fence_empty[%0d]: got rd/req/done %b want %b", i,
                 {stb_rd_en, req, fence_done}, {2'b00, done_pat[i]});
      end
      if (i == 1) begin
        @(posedge clk); #1;
        fence = 1'b0;
      end
    end
  endtask

  task automatic test_spurious_ack();
    logic [3:0] rd_pat  = 4'b0001;
    logic [3:0] req_pat = 4'b0110;
    @(posedge clk); #1;
    spur_ack = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({stb_rd_en, req, w_en, fence_done} !== 4'b0) begin
      n_miss++;
      $display("FAIL spur_during: got %b want 0000", {stb_rd_en, req, w_en, fence_done});
    end
    @(posedge clk); #1;
    spur_ack = 1'b0;
    ack_lat  = 2;
    push(32'h0000_6000, 32'h0BAD_F00D, 4'h6);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_vec++;
      if ({stb_rd_en, req} !== {rd_pat[i], req_pat[i]}) begin
        n_miss++;
        $display("FAIL spur_after[%0d]: got rd/req %b want %b", i, {stb_rd_en, req},
                 {rd_pat[i], req_pat[i]});
      end
    end
  endtask

  task automatic test_reset_mid();
    ack_lat = 0;
    @(posedge clk); #1;
    push(32'h0000_4000, 32'hCAFE_0000, 4'h8);
    repeat (3) @(negedge clk);
    n_vec++;
    if (req !== 1'b1) begin
      n_miss++;
      $display("FAIL rstmid_pre: got req %b want 1", req);
    end
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({req, w_en, waddr} !== 34'h0) begin
      n_miss++;
      $display("FAIL rstmid_async: got req/wen/addr %h want 0", {req, w_en, waddr});
    end
    q.delete(); refresh();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if ({stb_rd_en, req} !== 2'b00) begin
        n_miss++;
        $display("FAIL rstmid_quiet[%0d]: got rd/req %b want 00", i, {stb_rd_en, req});
      end
    end
    ack_lat = 1;
    @(posedge clk); #1;
    push(32'h0000_4100, 32'hCAFE_0001, 4'h1);
    @(negedge clk);
    n_vec++;
    if ({stb_rd_en, req} !== 2'b10) begin
      n_miss++;
      $display("FAIL rstmid_restart_rd: got rd/req %b want 10", {stb_rd_en, req});
    end
    @(negedge clk);
    n_vec++;
    if ({stb_rd_en, req, waddr} !== {2'b01, 32'h0000_4100}) begin
      n_miss++;
      $display("FAIL rstmid_restart_req: got %h want 100004100", {stb_rd_en, req, waddr});
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    logic exp_req, exp_err;
    ack_lat = 0;
    @(posedge clk); #1;
    push(32'h0000_5000, 32'h5555_AAAA, 4'h5);
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
`ifdef STB_DRAIN_TIMEOUT_EN
      exp_req = (i >= 1) && (i != 9);
      exp_err = (i >= 9);
`else
      exp_req = (i >= 1);
      exp_err = 1'b0;
`endif
      n_vec++;
      if ({stb_rd_en, req, drain_err} !== {i == 0, exp_req, exp_err}) begin
        n_miss++;
        $display("FAIL timeout_ctrl[%0d]: got rd/req/err %b want %b", i,
                 {stb_rd_en, req, drain_err}, {i == 0, exp_req, exp_err});
      end
      if (exp_req) begin
        n_vec++;
        if ({waddr, wdata, wsel} !== {32'h0000_5000, 32'h5555_AAAA, 4'h5}) begin
          n_miss++;
          $display("FAIL timeout_payload[%0d]: got %h", i, {waddr, wdata, wsel});
        end
      end
    end
    rst_n = 1'b0;
    q.delete(); refresh();
    #1;
    n_vec++;
    if ({req, drain_err} !== 2'b00) begin
      n_miss++;
      $display("FAIL timeout_reset: got req/err %b want 00", {req, drain_err});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_store();
    test_load_priority();
    test_fence();
    test_fence_empty();
    test_spurious_ack();
    test_reset_mid();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
